mod_checker_q: RTL and testbench

- Parametrised successor to the single-shot index checker. Accepts a stream of index requests, holds up to DEPTH of them in flight, and releases each one in order LATENCY cycles after acceptance.
- Returns each index on a done/ack output handshake.
- Sits between the index generator and the consumer of checked indices. Lets the generator issue back-to-back requests instead of waiting for each one to finish.

---
 rtl/mod_checker_q_if.sv | 23 ++
 rtl/mod_checker_q.sv | 87 ++++++++
 tb/tb_mod_checker_q.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mod_checker_q_if.sv
// rtl/mod_checker_q_if.sv - request/done handshake bundle for mod_checker_q
interface mod_checker_q_if #(
  parameter int INDEX_W = 3,
  parameter int CNT_W   = 3
);
  logic               en;
  logic [INDEX_W-1:0] index_in;
  logic               ready;
  logic               done;
  logic [INDEX_W-1:0] index_out;
  logic               done_ack;
  logic [CNT_W-1:0]   occupancy;

  modport master (
    output en, index_in, done_ack,
    input  ready, done, index_out, occupancy
  );

  modport slave (
    input  en, index_in, done_ack,
    output ready, done, index_out, occupancy
  );
endinterface

// File: rtl/mod_checker_q.sv
// rtl/mod_checker_q.sv - in-order index queue releasing each entry LATENCY cycles after accept
// Optional counters done_count/drop_count enabled by MOD_CHECKER_Q_STATS_EN.
module mod_checker_q #(
  parameter int INDEX_W = 3,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  mod_checker_q_if.slave   bus
`ifdef MOD_CHECKER_Q_STATS_EN
  ,
  output logic [15:0]      done_count,
  output logic [15:0]      drop_count
`endif
);
  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [7:0]      CD_INIT = 8'(LATENCY - 1);

  logic [INDEX_W-1:0] idx_mem [DEPTH];
  logic [7:0]         cnt_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   occ;
  logic               push;
  logic               pop;
  logic               slot_free;
  logic               head_mature;

  assign bus.ready     = (occ < DEPTH_C);
  assign bus.occupancy = occ;
  assign push          = bus.en && bus.ready;
  assign slot_free     = !bus.done || bus.done_ack;
  assign head_mature   = (occ != '0) && (cnt_mem[rd_ptr] == 8'd0);
  assign pop           = head_mature && slot_free;

  // Index storage carries no reset; validity is implied by occupancy.
  always_ff @(posedge clk) begin
    if (push) idx_mem[wr_ptr] <= bus.index_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      bus.done      <= 1'b0;
      bus.index_out <= '0;
      for (int i = 0; i < DEPTH; i++) cnt_mem[i] <= 8'd0;
    end else begin
      // Stale slots also count down; harmless since they are overwritten on push.
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt_mem[i] != 8'd0) cnt_mem[i] <= cnt_mem[i] - 8'd1;
      end
      if (push) begin
        cnt_mem[wr_ptr] <= CD_INIT;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        bus.done      <= 1'b1;
        bus.index_out <= idx_mem[rd_ptr];
      end else if (slot_free) begin
        bus.done <= 1'b0;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef MOD_CHECKER_Q_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_count <= 16'd0;
      drop_count <= 16'd0;
    end else begin
      if (bus.done && bus.done_ack) done_count <= done_count + 16'd1;
      if (bus.en && !bus.ready && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mod_checker_q.sv
// tb/tb_mod_checker_q.sv - directed self-checking bench for mod_checker_q
module tb_mod_checker_q;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mod_checker_q_if #(.INDEX_W(3), .CNT_W(3)) bus_a ();
  mod_checker_q_if #(.INDEX_W(3), .CNT_W(3)) bus_b ();

`ifdef MOD_CHECKER_Q_STATS_EN
  logic [15:0] a_done_count, a_drop_count, b_done_count, b_drop_count;
`endif

  mod_checker_q #(.INDEX_W(3), .LATENCY(4), .DEPTH(4), .CNT_W(3)) u_dut_l4 (
    .clk(clk), .rst(rst), .bus(bus_a)
`ifdef MOD_CHECKER_Q_STATS_EN
    , .done_count(a_done_count), .drop_count(a_drop_count)
`endif
  );

  mod_checker_q #(.INDEX_W(3), .LATENCY(1), .DEPTH(4), .CNT_W(3)) u_dut_l1 (
    .clk(clk), .rst(rst), .bus(bus_b)
`ifdef MOD_CHECKER_Q_STATS_EN
    , .done_count(b_done_count), .drop_count(b_drop_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] drain_exp [4];

  initial begin
    bus_a.en = 1'b0; bus_a.index_in = '0; bus_a.done_ack = 1'b0;
    bus_b.en = 1'b0; bus_b.index_in = '0; bus_b.done_ack = 1'b0;
    drain_exp[0] = 3'd2; drain_exp[1] = 3'd3; drain_exp[2] = 3'd4; drain_exp[3] = 3'd6;

    // reset state
    rst = 1'b0;
    tick(); tick();
    check("rst_done", 32'(bus_a.done), 32'd0);
    check("rst_index", 32'(bus_a.index_out), 32'd0);
    check("rst_occ", 32'(bus_a.occupancy), 32'd0);
    check("rst_ready", 32'(bus_a.ready), 32'd1);
    rst = 1'b1;

    // single request, ack high
    bus_a.done_ack = 1'b1;
    bus_a.en = 1'b1; bus_a.index_in = 3'd5;
    tick();
    bus_a.en = 1'b0;
    check("single_occ_e0", 32'(bus_a.occupancy), 32'd1);
    check("single_done_e0", 32'(bus_a.done), 32'd0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("single_occ_wait", 32'(bus_a.occupancy), 32'd1);
      check("single_done_wait", 32'(bus_a.done), 32'd0);
    end
    tick();
    check("single_done_e4", 32'(bus_a.done), 32'd1);
    check("single_index_e4", 32'(bus_a.index_out), 32'd5);
    check("single_occ_e4", 32'(bus_a.occupancy), 32'd0);
    tick();
    check("single_done_e5", 32'(bus_a.done), 32'd0);
    check("single_index_hold", 32'(bus_a.index_out), 32'd5);

    // burst of four with ack tied high
    for (int i = 0; i < 4; i++) begin
      bus_a.en = 1'b1; bus_a.index_in = 3'(i + 1);
      check("burst_ready", 32'(bus_a.ready), 32'd1);
      tick();
    end
    bus_a.en = 1'b0;
    check("burst_done_e3", 32'(bus_a.done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("burst_done", 32'(bus_a.done), 32'd1);
      check("burst_index", 32'(bus_a.index_out), 32'(i + 1));
    end
    tick();
    check("burst_done_end", 32'(bus_a.done), 32'd0);

    // backpressure: six requests, ack low; fifth is refused while full
    bus_a.done_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_a.en = 1'b1; bus_a.index_in = 3'(i + 1);
      check("bp_ready", 32'(bus_a.ready), (i == 4) ? 32'd0 : 32'd1);
      tick();
      if (i == 4) begin
        check("bp_done_e4", 32'(bus_a.done), 32'd1);
        check("bp_index_e4", 32'(bus_a.index_out), 32'd1);
        check("bp_occ_e4", 32'(bus_a.occupancy), 32'd3);
      end
    end
    bus_a.en = 1'b0;
    check("bp_occ_full", 32'(bus_a.occupancy), 32'd4);
    check("bp_ready_full", 32'(bus_a.ready), 32'd0);
`ifdef MOD_CHECKER_Q_STATS_EN
    check("bp_drop_count", 32'(a_drop_count), 32'd1);
`endif

    // stall: output must hold for ten cycles
    for (int c = 0; c < 10; c++) begin
      tick();
      check("stall_done", 32'(bus_a.done), 32'd1);
      check("stall_index", 32'(bus_a.index_out), 32'd1);
    end
    check("stall_occ", 32'(bus_a.occupancy), 32'd4);

    // drain in order, one per edge
    bus_a.done_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_done", 32'(bus_a.done), 32'd1);
      check("drain_index", 32'(bus_a.index_out), 32'(drain_exp[i]));
      check("drain_occ", 32'(bus_a.occupancy), 32'(3 - i));
    end
    tick();
    check("drain_done_end", 32'(bus_a.done), 32'd0);
`ifdef MOD_CHECKER_Q_STATS_EN
    check("done_count", 32'(a_done_count), 32'd10);
`endif

    // reset mid-flight
    bus_a.done_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_a.en = (i < 4); bus_a.index_in = 3'(i + 1);
      tick();
    end
    bus_a.en = 1'b0;
    check("mid_done", 32'(bus_a.done), 32'd1);
    check("mid_occ", 32'(bus_a.occupancy), 32'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_done", 32'(bus_a.done), 32'd0);
    check("mid_rst_index", 32'(bus_a.index_out), 32'd0);
    check("mid_rst_occ", 32'(bus_a.occupancy), 32'd0);
`ifdef MOD_CHECKER_Q_STATS_EN
    check("mid_rst_done_count", 32'(a_done_count), 32'd0);
    check("mid_rst_drop_count", 32'(a_drop_count), 32'd0);
`endif
    bus_a.done_ack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("mid_no_done", 32'(bus_a.done), 32'd0);
    end

    // LATENCY=1 corner on the second instance
    bus_b.done_ack = 1'b1;
    bus_b.en = 1'b1; bus_b.index_in = 3'd7;
    tick();
    check("l1_occ_e0", 32'(bus_b.occupancy), 32'd1);
    check("l1_done_e0", 32'(bus_b.done), 32'd0);
    bus_b.index_in = 3'd3;
    tick();
    bus_b.en = 1'b0;
    check("l1_done_e1", 32'(bus_b.done), 32'd1);
    check("l1_index_e1", 32'(bus_b.index_out), 32'd7);
    check("l1_occ_pushpop", 32'(bus_b.occupancy), 32'd1);
    tick();
    check("l1_done_e2", 32'(bus_b.done), 32'd1);
    check("l1_index_e2", 32'(bus_b.index_out), 32'd3);
    check("l1_occ_e2", 32'(bus_b.occupancy), 32'd0);
    tick();
    check("l1_done_e3", 32'(bus_b.done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
